// File: rtl/pol_seq_ctrl_pkg.sv
// Shared state encoding and defaults for the polarization sequencer.
// The optional dwell watchdog is enabled with POL_SEQ_WATCHDOG_EN.
package pol_seq_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, SEEK, DWELL, BLANK, DONE} state_t;

  localparam int DW_DEF        = 16;
  localparam int RST_DWELL     = 1;
  localparam int WD_MARGIN_DEF = 8;

endpackage

// File: rtl/pol_seq_dwell_tbl.sv
// Per-channel dwell register file: a written 0 is stored as 1 so the timer never free-runs.
// Write takes effect on the next edge; read is combinational; no backpressure.
module pol_seq_dwell_tbl
  import pol_seq_ctrl_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [$clog2(NCH)-1:0] waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [$clog2(NCH)-1:0] raddr,
  output logic [DW-1:0]          rdata
);

  logic [DW-1:0] mem [NCH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) mem[i] <= DW'(RST_DWELL);
    end else if (we && (int'(waddr) < NCH)) begin
      mem[waddr] <= (wdata == '0) ? DW'(RST_DWELL) : wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pol_seq_ctrl.sv
// Polarization LED sequencer, one channel per dwell with blanking gaps; POL_SEQ_WATCHDOG_EN adds a dwell watchdog.
// Outputs are registered with the state; no backpressure, pacing comes from timer_timeout.
module pol_seq_ctrl
  import pol_seq_ctrl_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int BLANK_CYC = 2,
  parameter int DW        = DW_DEF
`ifdef POL_SEQ_WATCHDOG_EN
  ,
  parameter int WD_MARGIN = WD_MARGIN_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   single,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_addr,
  input  logic [DW-1:0]          cfg_data,
  input  logic [NCH-1:0]         ch_mask,
  input  logic                   timer_timeout,
  output logic                   timer_start,
  output logic [DW-1:0]          timer_setcount,
  output logic [NCH-1:0]         led_en,
  output logic                   cam_trig,
  output logic [$clog2(NCH)-1:0] cur_ch,
  output logic                   busy,
  output logic                   frame_done
`ifdef POL_SEQ_WATCHDOG_EN
  ,
  output logic                   wd_err
`endif
);

  localparam int AW = $clog2(NCH);
  localparam int BW = $clog2(BLANK_CYC + 1);

  state_t         state;
  logic [AW:0]    seek_idx;
  logic [NCH-1:0] mask_q;
  logic [BW-1:0]  blank_cnt;
  logic           one_shot;
  logic           start_req;
  logic           seek_hit;
  logic           more;
  logic [AW-1:0]  seek_ch;
  logic [DW-1:0]  tbl_rdata;

  function automatic logic any_from(input logic [NCH-1:0] m, input int from);
    any_from = 1'b0;
    for (int i = 0; i < NCH; i++) if (i >= from && m[i]) any_from = 1'b1;
  endfunction

  function automatic logic [AW-1:0] first_from(input logic [NCH-1:0] m, input int from);
    first_from = '0;
    for (int i = NCH - 1; i >= 0; i--) if (i >= from && m[i]) first_from = AW'(i);
  endfunction

  // The live mask is only looked at in SEEK; BLANK decides on the copy taken there.
  assign seek_hit = any_from(ch_mask, int'(seek_idx));
  assign seek_ch  = first_from(ch_mask, int'(seek_idx));
  assign more     = any_from(mask_q, int'(cur_ch) + 1);

`ifdef POL_SEQ_WATCHDOG_EN
  logic [DW:0] wd_cnt;
  logic [DW:0] wd_limit;
  assign wd_limit  = {1'b0, timer_setcount} + (DW+1)'(WD_MARGIN);
  assign start_req = (run | single) & (|ch_mask) & ~wd_err;
`else
  assign start_req = (run | single) & (|ch_mask);
`endif

  pol_seq_dwell_tbl #(.NCH(NCH), .DW(DW)) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (seek_ch),
    .rdata (tbl_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      seek_idx       <= '0;
      mask_q         <= '0;
      blank_cnt      <= '0;
      one_shot       <= 1'b0;
      timer_start    <= 1'b0;
      timer_setcount <= DW'(RST_DWELL);
      led_en         <= '0;
      cam_trig       <= 1'b0;
      cur_ch         <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
`ifdef POL_SEQ_WATCHDOG_EN
      wd_cnt         <= '0;
      wd_err         <= 1'b0;
`endif
    end else begin
      cam_trig   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start_req) begin
          state    <= SEEK;
          seek_idx <= '0;
          one_shot <= single & ~run;
          busy     <= 1'b1;
        end
        SEEK: begin
          mask_q <= ch_mask;
          if (seek_hit) begin
            state          <= DWELL;
            cur_ch         <= seek_ch;
            led_en         <= NCH'(1) << seek_ch;
            timer_start    <= 1'b1;
            timer_setcount <= tbl_rdata;
            cam_trig       <= 1'b1;
`ifdef POL_SEQ_WATCHDOG_EN
            wd_cnt         <= '0;
`endif
          end else begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DWELL: begin
          if (timer_timeout) begin
            state       <= BLANK;
            led_en      <= '0;
            timer_start <= 1'b0;
            blank_cnt   <= '0;
          end
`ifdef POL_SEQ_WATCHDOG_EN
          else if (wd_cnt == wd_limit) begin
            state       <= IDLE;
            led_en      <= '0;
            timer_start <= 1'b0;
            busy        <= 1'b0;
            one_shot    <= 1'b0;
            wd_err      <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYC - 1)) begin
            if (more) begin
              state    <= SEEK;
              seek_idx <= (AW+1)'(cur_ch) + 1'b1;
            end else begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        DONE: begin
          if (run && !one_shot) begin
            state    <= SEEK;
            seek_idx <= '0;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            one_shot <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pol_seq_ctrl.sv
// Scoreboard bench for pol_seq_ctrl with a behavioural dwell timer (timeout at t+D+1 after start rises).
// Build with POL_SEQ_WATCHDOG_EN defined to also exercise the watchdog.
module tb_pol_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        single;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0]  ch_mask;
  logic        timer_timeout;
  logic        timer_start;
  logic [15:0] timer_setcount;
  logic [3:0]  led_en;
  logic        cam_trig;
  logic [1:0]  cur_ch;
  logic        busy;
  logic        frame_done;
`ifdef POL_SEQ_WATCHDOG_EN
  logic        wd_err;
`endif

  pol_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .single         (single),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .ch_mask        (ch_mask),
    .timer_timeout  (timer_timeout),
    .timer_start    (timer_start),
    .timer_setcount (timer_setcount),
    .led_en         (led_en),
    .cam_trig       (cam_trig),
    .cur_ch         (cur_ch),
    .busy           (busy),
`ifdef POL_SEQ_WATCHDOG_EN
    .wd_err         (wd_err),
`endif
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: counts cycles while start is high, fires when count reaches D+1.
  logic tmr_en;
  int   tcnt;
  always @(posedge clk) tcnt <= (timer_start && !timer_timeout) ? tcnt + 1 : 0;
  assign timer_timeout = tmr_en && timer_start && (tcnt == int'(timer_setcount) + 1);

  typedef struct {
    int kind;  // 0 = dwell episode, 1 = frame_done pulse
    int ch;
    int on;
    int sc;
    int gap;   // zero cycles before this dwell, -1 = not checked
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic exp_dw(input int ch, input int on, input int sc, input int gap);
    exp_t e;
    e.kind = 0; e.ch = ch; e.on = on; e.sc = sc; e.gap = gap;
    expq.push_back(e);
  endtask

  task automatic exp_fr();
    exp_t e;
    e.kind = 1; e.ch = 0; e.on = 0; e.sc = 0; e.gap = -1;
    expq.push_back(e);
  endtask

  // Monitor: rebuilds each lit episode and frame_done pulse and checks them against the queue.
  initial begin : monitor
    logic [3:0] prev;
    int on_cnt, gap, ch, sc, oh;
    exp_t e;
    prev = '0; on_cnt = 0; gap = 0; ch = 0; sc = 0; oh = 1;
    forever begin
      @(posedge clk);
      #1;
      if (led_en != '0) begin
        if (!$onehot(led_en)) oh = 0;
        if (prev == '0) begin
          chk("trig_at_entry", int'(cam_trig), 1);
          chk("dwell_pending", int'(expq.size() != 0 && expq[0].kind == 0), 1);
          if (expq.size() != 0 && expq[0].kind == 0 && expq[0].gap >= 0)
            chk("blank_gap", gap, expq[0].gap);
          on_cnt = 1;
          oh = int'($onehot(led_en));
          sc = int'(timer_setcount);
          for (int i = 0; i < 4; i++) if (led_en[i]) ch = i;
        end else begin
          on_cnt++;
          chk("trig_only_at_entry", int'(cam_trig), 0);
        end
      end else begin
        if (prev != '0) begin
          if (expq.size() != 0 && expq[0].kind == 0) begin
            e = expq.pop_front();
            chk("dwell_ch", ch, e.ch);
            chk("dwell_on_time", on_cnt, e.on);
            chk("dwell_setcount", sc, e.sc);
            chk("led_onehot", oh, 1);
          end else begin
            chk("dwell_end_pending", int'(expq.size() != 0 && expq[0].kind == 0), 1);
          end
          gap = 1;
        end else begin
          gap++;
        end
        chk("trig_without_led", int'(cam_trig), 0);
      end
      if (frame_done) begin
        chk("frame_pending", int'(expq.size() != 0 && expq[0].kind == 1), 1);
        if (expq.size() != 0 && expq[0].kind == 1) void'(expq.pop_front());
      end
      prev = led_en;
    end
  end

  task automatic cfg_wr(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_single();
    @(negedge clk);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
  endtask

  // what: 0 = cam_trig, 1 = frame_done, 2 = back in IDLE
  task automatic wait_for(input int what, input string name);
    int hit;
    hit = 0;
    for (int i = 0; i < 400 && hit == 0; i++) begin
      @(negedge clk);
      case (what)
        0:       hit = int'(cam_trig);
        1:       hit = int'(frame_done);
        default: hit = int'(!busy);
      endcase
    end
    chk(name, hit, 1);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; single = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; ch_mask = '0; tmr_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_timer_start", int'(timer_start), 0);
    chk("rst_setcount", int'(timer_setcount), 1);
    chk("rst_led_en", int'(led_en), 0);
    chk("rst_cam_trig", int'(cam_trig), 0);
    chk("rst_cur_ch", int'(cur_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);

    // Single frame over all four channels: on-time D+2, gap = two blank cycles plus the seek cycle.
    cfg_wr(0, 3); cfg_wr(1, 5); cfg_wr(2, 2); cfg_wr(3, 4);
    ch_mask = 4'b1111;
    exp_dw(0, 5, 3, -1); exp_dw(1, 7, 5, 3); exp_dw(2, 4, 2, 3); exp_dw(3, 6, 4, 3); exp_fr();
    pulse_single();
    wait_for(2, "t1_idle");
    repeat (3) @(negedge clk);
    chk("t1_stays_idle", int'(busy), 0);

    // Continuous framing on channels 1 and 3; frame-to-frame gap adds the DONE cycle.
    ch_mask = 4'b1010;
    exp_dw(1, 7, 5, -1); exp_dw(3, 6, 4, 3); exp_fr();
    exp_dw(1, 7, 5, 4);  exp_dw(3, 6, 4, 3); exp_fr();
    @(negedge clk);
    run = 1'b1;
    wait_for(1, "t2_frame1_done");
    wait_for(0, "t2_frame2_start");
    run = 1'b0;
    wait_for(2, "t2_idle");

    // Zero dwell is stored as one.
    cfg_wr(2, 0);
    ch_mask = 4'b0100;
    exp_dw(2, 3, 1, -1); exp_fr();
    pulse_single();
    wait_for(2, "t3_idle");

    // Rewriting channel 1 mid-dwell only affects its next visit.
    ch_mask = 4'b0010;
    exp_dw(1, 7, 5, -1); exp_fr();
    exp_dw(1, 12, 10, 4); exp_fr();
    @(negedge clk);
    run = 1'b1;
    wait_for(0, "t4_dwell1_start");
    cfg_wr(1, 10);
    wait_for(1, "t4_frame1_done");
    wait_for(0, "t4_frame2_start");
    run = 1'b0;
    wait_for(2, "t4_idle");

    // Asynchronous reset in the second cycle of channel 2's dwell.
    cfg_wr(2, 4);
    ch_mask = 4'b0100;
    exp_dw(2, 2, 4, -1);
    pulse_single();
    wait_for(0, "t5_dwell_start");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_led_off_async", int'(led_en), 0);
    chk("t5_start_off_async", int'(timer_start), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_rst", int'(busy), 0);
    chk("t5_setcount_after_rst", int'(timer_setcount), 1);
    // Table is back to all-1, so channel 2 now dwells for 3 cycles.
    exp_dw(2, 3, 1, -1); exp_fr();
    pulse_single();
    wait_for(2, "t5_idle");

`ifdef POL_SEQ_WATCHDOG_EN
    // Timer never fires: watchdog ends the dwell after D+1+8 cycles and locks out new requests.
    cfg_wr(0, 3);
    ch_mask = 4'b0001;
    tmr_en = 1'b0;
    exp_dw(0, 12, 3, -1);
    pulse_single();
    wait_for(2, "t6_idle");
    chk("t6_wd_err", int'(wd_err), 1);
    chk("t6_led_off", int'(led_en), 0);
    pulse_single();
    repeat (4) @(negedge clk);
    chk("t6_single_ignored", int'(busy), 0);
    chk("t6_wd_err_sticky", int'(wd_err), 1);
    tmr_en = 1'b1;
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
